// File: rtl/prga.sv
// prga: RC4 pseudo-random generation stage; XORs CT with the keystream into PT.
// Optional keystream tap ports (ks_byte/ks_valid) enabled by PRGA_KS_TAP_EN.
module prga #(
   parameter int MSG_AW = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   output logic              rdy,
   output logic [7:0]        s_addr,
   input  logic [7:0]        s_rddata,
   output logic [7:0]        s_wrdata,
   output logic              s_wren,
   output logic [MSG_AW-1:0] ct_addr,
   input  logic [7:0]        ct_rddata,
   output logic [MSG_AW-1:0] pt_addr,
   output logic [7:0]        pt_wrdata,
   output logic              pt_wren
`ifdef PRGA_KS_TAP_EN
   ,
   output logic [7:0]        ks_byte,
   output logic              ks_valid
`endif
);

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      RD_LEN = 4'd1,
      LD_LEN = 4'd2,
      RD_I   = 4'd3,
      CALC   = 4'd4,
      RD_J   = 4'd5,
      WR_J   = 4'd6,
      WR_I   = 4'd7,
      RD_PAD = 4'd8,
      XOR    = 4'd9
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        i_q, i_d;
   logic [7:0]        j_q, j_d;
   logic [MSG_AW-1:0] k_q, k_d;
   logic [7:0]        len_q, len_d;
   logic [7:0]        si_q, si_d;
   logic [7:0]        sj_q, sj_d;

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      len_d   = len_q;
      si_d    = si_q;
      sj_d    = sj_q;
      case (state_q)
         IDLE: begin
            i_d = 8'd0;
            j_d = 8'd0;
            k_d = MSG_AW'(1);
            if (en) state_d = RD_LEN;
         end
         RD_LEN: state_d = LD_LEN;
         LD_LEN: begin
            len_d   = ct_rddata;
            state_d = (ct_rddata == 8'd0) ? IDLE : RD_I;
         end
         RD_I: begin
            i_d     = i_q + 8'd1;
            state_d = CALC;
         end
         CALC: begin
            si_d    = s_rddata;
            j_d     = j_q + s_rddata;
            state_d = RD_J;
         end
         RD_J: state_d = WR_J;
         WR_J: begin
            sj_d    = s_rddata;
            state_d = WR_I;
         end
         WR_I:   state_d = RD_PAD;
         RD_PAD: state_d = XOR;
         XOR: begin
            k_d     = k_q + MSG_AW'(1);
            // k stops at len, so an 8-bit len never overflows k
            state_d = (k_q == MSG_AW'(len_q)) ? IDLE : RD_I;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rdy       = 1'b0;
      s_addr    = 8'd0;
      s_wrdata  = 8'd0;
      s_wren    = 1'b0;
      ct_addr   = '0;
      pt_addr   = '0;
      pt_wrdata = 8'd0;
      pt_wren   = 1'b0;
      case (state_q)
         IDLE: rdy = 1'b1;
         LD_LEN: begin
            pt_wrdata = ct_rddata;
            pt_wren   = 1'b1;
         end
         RD_I: s_addr = i_q + 8'd1;
         RD_J: s_addr = j_q;
         WR_J: begin
            s_addr   = j_q;
            s_wrdata = si_q;
            s_wren   = 1'b1;
         end
         WR_I: begin
            s_addr   = i_q;
            s_wrdata = sj_q;
            s_wren   = 1'b1;
         end
         RD_PAD: begin
            s_addr  = si_q + sj_q;
            ct_addr = k_q;
         end
         XOR: begin
            pt_addr   = k_q;
            pt_wrdata = s_rddata ^ ct_rddata;
            pt_wren   = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef PRGA_KS_TAP_EN
   always_comb begin
      ks_valid = (state_q == XOR);
      ks_byte  = (state_q == XOR) ? s_rddata : 8'd0;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         i_q     <= 8'd0;
         j_q     <= 8'd0;
         k_q     <= '0;
         len_q   <= 8'd0;
         si_q    <= 8'd0;
         sj_q    <= 8'd0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         len_q   <= len_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
      end
   end

endmodule
